// File: rtl/mux_pipe_reg.sv
// N-way operand select mux feeding a pipeline register with stall, flush,
// valid tracking and a sticky saturating count of out-of-range selects.
module mux_pipe_reg #(
  parameter int                 WIDTH         = 32,
  parameter int                 NUM_INPUTS    = 3,
  parameter int                 SEL_WIDTH     = 2,
  parameter logic [WIDTH-1:0]   DEFAULT_VALUE = '0,
  parameter int                 ERR_CNT_WIDTH = 8
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [WIDTH*NUM_INPUTS-1:0]   IN_BUS,
  input  logic [SEL_WIDTH-1:0]          SELECT,
  input  logic                          IN_VALID,
  input  logic                          STALL,
  input  logic                          FLUSH,
  output logic [WIDTH-1:0]              OUT,
  output logic                          OUT_VALID,
  output logic                          SEL_ERR,
  output logic [ERR_CNT_WIDTH-1:0]      ERR_COUNT
);

  logic [WIDTH-1:0]         w_sel_data;
  logic                     w_sel_bad;
  logic                     w_load;
  logic                     w_count_err;

  logic [WIDTH-1:0]         r_out;
  logic                     r_out_valid;
  logic                     r_sel_err;
  logic [ERR_CNT_WIDTH-1:0] r_err_cnt;

  // Default first so an out-of-range select yields a defined value, never X.
  always_comb begin
    w_sel_data = DEFAULT_VALUE;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (SELECT == SEL_WIDTH'(k)) begin
        w_sel_data = IN_BUS[k*WIDTH +: WIDTH];
      end
    end
  end

  generate
    if (NUM_INPUTS >= (2 ** SEL_WIDTH)) begin : g_full_decode
      assign w_sel_bad = 1'b0;
    end else begin : g_partial_decode
      assign w_sel_bad = (int'(SELECT) >= NUM_INPUTS);
    end
  endgenerate

  assign w_load      = !FLUSH && !STALL;
  assign w_count_err = w_load && IN_VALID && w_sel_bad;

  // Priority: reset, then flush (beats stall), then stall, then load.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_sel_err   <= 1'b0;
      r_err_cnt   <= '0;
    end else if (FLUSH) begin
      r_out_valid <= 1'b0;
      r_sel_err   <= 1'b0;
    end else if (!STALL) begin
      r_out       <= w_sel_data;
      r_out_valid <= IN_VALID;
      r_sel_err   <= w_sel_bad && IN_VALID;
      if (w_count_err && (r_err_cnt != {ERR_CNT_WIDTH{1'b1}})) begin
        r_err_cnt <= r_err_cnt + ERR_CNT_WIDTH'(1);
      end
    end
  end

  assign OUT       = r_out;
  assign OUT_VALID = r_out_valid;
  assign SEL_ERR   = r_sel_err;
  assign ERR_COUNT = r_err_cnt;

endmodule

// File: doc/mux_pipe_reg.md
Name: mux_pipe_reg

Overview:
- Parametrised N-way operand select mux with an output pipeline register, for datapath select points (ALU operand, forwarding, PC source) that must also absorb the stage boundary.
- Adds stall (hold), flush (bubble), valid tracking and out-of-range select detection with a sticky saturating error counter.
- Invalid selects never propagate X; they produce a defined default value.

Parameters:
- WIDTH, 32, data width of each input and of OUT.
- NUM_INPUTS, 3, number of selectable inputs (2..16).
- SEL_WIDTH, 2, width of SELECT; must satisfy 2**SEL_WIDTH >= NUM_INPUTS.
- DEFAULT_VALUE, 0, WIDTH-bit value loaded when SELECT >= NUM_INPUTS.
- ERR_CNT_WIDTH, 8, width of the saturating error counter.

Ports:
- CLK, input, 1, clock; all state updates on rising edge.
- RESET, input, 1, synchronous, active-high reset.
- IN_BUS, input, WIDTH*NUM_INPUTS, packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- SELECT, input, SEL_WIDTH, binary index of the chosen input.
- IN_VALID, input, 1, qualifies IN_BUS/SELECT this cycle.
- STALL, input, 1, hold all registered outputs.
- FLUSH, input, 1, insert a bubble.
- OUT, output, WIDTH, registered selected data.
- OUT_VALID, output, 1, registered valid.
- SEL_ERR, output, 1, registered; 1 when the value in OUT came from an out-of-range SELECT.
- ERR_COUNT, output, ERR_CNT_WIDTH, saturating count of valid out-of-range selects.

Behaviour:
- Combinational select: sel_data = input[SELECT] if SELECT < NUM_INPUTS, else DEFAULT_VALUE; sel_bad = (SELECT >= NUM_INPUTS).
- Latency: exactly 1 cycle from IN_BUS/SELECT to OUT when not stalled.
- Per-edge priority (highest first):
  1. RESET=1: OUT=0, OUT_VALID=0, SEL_ERR=0, ERR_COUNT=0.
  2. FLUSH=1: OUT_VALID=0, SEL_ERR=0, OUT unchanged, ERR_COUNT unchanged. FLUSH overrides STALL.
  3. STALL=1: OUT, OUT_VALID, SEL_ERR and ERR_COUNT all hold.
  4. Otherwise (load): OUT=sel_data, OUT_VALID=IN_VALID, SEL_ERR=sel_bad & IN_VALID.
- ERR_COUNT increments by 1 only on a load cycle with IN_VALID=1 and sel_bad=1.
- ERR_COUNT saturates at all-ones and never wraps. It clears only on RESET; FLUSH does not clear it.
- IN_VALID=0 on a load: OUT still takes sel_data (don't-care for consumers), OUT_VALID=0, and no error is counted.
- RESET during a stall or flush: the reset values win on that edge.
- When NUM_INPUTS == 2**SEL_WIDTH, sel_bad is constant 0 and SEL_ERR/ERR_COUNT stay 0.
- No X on OUT after the first reset, for any SELECT value.
- Inputs that are unused after the parameter elaboration are ignored.

Test Plan:
- Reset then load: RESET 1 cycle; IN_BUS={32'h33333333,32'h22222222,32'h11111111}, SELECT=1, IN_VALID=1 -> next edge OUT=32'h22222222, OUT_VALID=1, SEL_ERR=0, ERR_COUNT=0.
- Invalid select (default params): SELECT=3, IN_VALID=1 -> OUT=32'h0, SEL_ERR=1, ERR_COUNT=1. Repeat with IN_VALID=0 -> OUT_VALID=0, SEL_ERR=0, ERR_COUNT stays 1.
- Stall/flush priority: hold OUT=32'h11111111/valid; STALL=1 with SELECT=2 for 3 cycles -> OUT holds 32'h11111111. STALL=1 and FLUSH=1 together -> OUT_VALID=0, OUT still 32'h11111111.
- Saturation: ERR_CNT_WIDTH=4; apply 20 consecutive valid SELECT=3 loads -> ERR_COUNT reaches 15 and stays 15. A FLUSH leaves it at 15; RESET returns it to 0.
- Back-to-back throughput: SELECT sequence 0,1,2,0 on consecutive cycles with IN_VALID=1 -> OUT follows 32'h11111111, 32'h22222222, 32'h33333333, 32'h11111111, one cycle late, with no bubbles.
- Parametrisation: WIDTH=8, NUM_INPUTS=4, SEL_WIDTH=2; sweep all four SELECT values -> correct byte each time, SEL_ERR never asserts.
